entity_motion_engine: RTL and testbench

- Parametrised successor to the single-ship position logic.
- Holds a table of N_ENTITIES game entities (asteroids or shots) and advances every live entity by one step per motion tick, one entity per cycle.
- Applies screen wrap-around and per-entity time-to-live expiry, and services spawn and kill requests.
- Sits between the move-rate divider and the draw controller; its flat entity bus feeds the draw controller's asteroid or shot register port directly.

---
 rtl/entity_pkg.sv | 59 +++++
 rtl/entity_stepper.sv | 49 ++++
 rtl/entity_motion_engine.sv | 120 ++++++++++++
 tb/tb_entity_motion_engine.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entity_pkg.sv
// Shared types for the entity motion engine: entity word layout, FSM states
// and the heading-to-step lookup.
package entity_pkg;

  localparam int unsigned ENTITY_SIZE = 34;
  localparam int unsigned DIR_LSB     = 0;
  localparam int unsigned DIR_W       = 6;
  localparam int unsigned X_LSB       = 6;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_LSB       = 16;
  localparam int unsigned Y_W         = 10;
  localparam int unsigned TTL_LSB     = 26;
  localparam int unsigned TTL_W       = 7;
  localparam int unsigned ALIVE_BIT   = 33;

  typedef struct packed {
    logic             alive;
    logic [TTL_W-1:0] ttl;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   x;
    logic [DIR_W-1:0] dir;
  } entity_t;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } step_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Unit step per 16-point compass heading; h=0 points up the screen.
  function automatic step_t heading_step(input logic [3:0] h);
    step_t s;
    case (h)
      4'd0:    s = '{dx:  3'sd0, dy: -3'sd2};
      4'd1:    s = '{dx:  3'sd1, dy: -3'sd2};
      4'd2:    s = '{dx:  3'sd1, dy: -3'sd1};
      4'd3:    s = '{dx:  3'sd2, dy: -3'sd1};
      4'd4:    s = '{dx:  3'sd2, dy:  3'sd0};
      4'd5:    s = '{dx:  3'sd2, dy:  3'sd1};
      4'd6:    s = '{dx:  3'sd1, dy:  3'sd1};
      4'd7:    s = '{dx:  3'sd1, dy:  3'sd2};
      4'd8:    s = '{dx:  3'sd0, dy:  3'sd2};
      4'd9:    s = '{dx: -3'sd1, dy:  3'sd2};
      4'd10:   s = '{dx: -3'sd1, dy:  3'sd1};
      4'd11:   s = '{dx: -3'sd2, dy:  3'sd1};
      4'd12:   s = '{dx: -3'sd2, dy:  3'sd0};
      4'd13:   s = '{dx: -3'sd2, dy: -3'sd1};
      4'd14:   s = '{dx: -3'sd1, dy: -3'sd1};
      default: s = '{dx: -3'sd1, dy: -3'sd2};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/entity_stepper.sv
// Combinational single-entity advance: heading step, screen wrap, ttl expiry.
module entity_stepper
  import entity_pkg::*;
#(
  parameter int unsigned SPEED    = 1,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input  entity_t cur,
  output entity_t nxt_c
);

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);
  localparam logic signed [10:0] W_S     = 11'(SCREEN_W);
  localparam logic signed [10:0] H_S     = 11'(SCREEN_H);

  step_t             st;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic              unused_sign;

  always_comb begin
    st = heading_step(cur.dir[5:2]);
    dx = 11'(st.dx) * SPEED_S;
    dy = 11'(st.dy) * SPEED_S;
    nx = $signed({1'b0, cur.x}) + dx;
    ny = $signed({1'b0, cur.y}) + dy;
    // Single correction suffices: |step| is far below either modulus.
    if (nx < 11'sd0)     nx = nx + W_S;
    else if (nx >= W_S)  nx = nx - W_S;
    if (ny < 11'sd0)     ny = ny + H_S;
    else if (ny >= H_S)  ny = ny - H_S;

    nxt_c = cur;
    if (cur.alive) begin
      nxt_c.x = nx[9:0];
      nxt_c.y = ny[9:0];
      if (cur.ttl != '0) begin
        nxt_c.ttl = cur.ttl - 7'd1;
        if (cur.ttl == 7'd1) nxt_c.alive = 1'b0;
      end
    end
  end

  assign unused_sign = nx[10] ^ ny[10];

endmodule

// File: rtl/entity_motion_engine.sv
// Entity table with per-tick sweep (one slot per cycle), spawn into the lowest
// free slot, kill by index, and dropped-tick accounting.
module entity_motion_engine
  import entity_pkg::*;
#(
  parameter int unsigned N_ENTITIES = 10,
  parameter int unsigned SPEED      = 1,
  parameter int unsigned SCREEN_W   = 320,
  parameter int unsigned SCREEN_H   = 240
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              tick,
  input  logic                              spawn_valid,
  input  logic [ENTITY_SIZE-1:0]            spawn_data,
  output logic                              spawn_ready,
  input  logic                              kill_valid,
  input  logic [5:0]                        kill_idx,
  output logic [N_ENTITIES*ENTITY_SIZE-1:0] entities,
  output logic [6:0]                        alive_count,
  output logic                              busy,
  output logic                              frame_done,
  output logic [7:0]                        overrun_cnt
);

  localparam logic [5:0] IDX_LAST = 6'(N_ENTITIES - 1);

  entity_t    tbl [N_ENTITIES];
  entity_t    cur;
  entity_t    stepped;
  state_t     state;
  logic [5:0] idx;
  logic       ready_en;
  logic       any_free;
  logic [5:0] free_idx;
  logic       spawn_accept;

  // Sweep mux, lowest-free-slot priority encoder and alive popcount.
  always_comb begin
    cur         = '0;
    any_free    = 1'b0;
    free_idx    = '0;
    alive_count = '0;
    for (int i = int'(N_ENTITIES) - 1; i >= 0; i--) begin
      if (idx == 6'(i)) cur = tbl[i];
      if (!tbl[i].alive) begin
        any_free = 1'b1;
        free_idx = 6'(i);
      end
      alive_count = alive_count + 7'(tbl[i].alive);
    end
  end

  assign spawn_ready  = ready_en && (state == IDLE) && any_free && !tick;
  assign spawn_accept = spawn_valid && spawn_ready;

  entity_stepper #(
    .SPEED   (SPEED),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_stepper (
    .cur  (cur),
    .nxt_c(stepped)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
      ready_en    <= 1'b0;
      for (int i = 0; i < int'(N_ENTITIES); i++) tbl[i] <= '0;
    end else begin
      ready_en   <= 1'b1;
      frame_done <= 1'b0;
      if (tick && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == IDX_LAST) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Later writes win: a kill landing on the swept slot keeps the new position.
      for (int i = 0; i < int'(N_ENTITIES); i++) begin
        if (spawn_accept && (free_idx == 6'(i))) begin
          tbl[i]       <= entity_t'(spawn_data);
          tbl[i].alive <= 1'b1;
        end
        if ((state == SWEEP) && (idx == 6'(i))) tbl[i] <= stepped;
        if (kill_valid && (kill_idx == 6'(i))) tbl[i].alive <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < int'(N_ENTITIES); g++) begin : g_flat
    assign entities[g*ENTITY_SIZE +: ENTITY_SIZE] = tbl[g];
  end

endmodule

// File: tb/tb_entity_motion_engine.sv
// Self-checking bench for entity_motion_engine against a field-level table model.
module tb_entity_motion_engine;

  localparam int N     = 10;
  localparam int SPEED = 1;
  localparam int W     = 320;
  localparam int H     = 240;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            tick = 1'b0;
  logic            spawn_valid = 1'b0;
  logic [33:0]     spawn_data = '0;
  logic            spawn_ready;
  logic            kill_valid = 1'b0;
  logic [5:0]      kill_idx = '0;
  logic [N*34-1:0] entities;
  logic [6:0]      alive_count;
  logic            busy;
  logic            frame_done;
  logic [7:0]      overrun_cnt;

  int vectors = 0;
  int miscompares = 0;

  int m_x[N];
  int m_y[N];
  int m_dir[N];
  int m_ttl[N];
  bit m_alive[N];
  int dx_t[16] = '{0, 1, 1, 2, 2, 2, 1, 1, 0, -1, -1, -2, -2, -2, -1, -1};
  int dy_t[16] = '{-2, -2, -1, -1, 0, 1, 1, 2, 2, 2, 1, 1, 0, -1, -1, -2};

  entity_motion_engine #(
    .N_ENTITIES(N),
    .SPEED     (SPEED),
    .SCREEN_W  (W),
    .SCREEN_H  (H)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .spawn_valid(spawn_valid),
    .spawn_data (spawn_data),
    .spawn_ready(spawn_ready),
    .kill_valid (kill_valid),
    .kill_idx   (kill_idx),
    .entities   (entities),
    .alive_count(alive_count),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [33:0] exp_word(input int i);
    logic [33:0] w;
    w = {m_alive[i], 7'(m_ttl[i]), 10'(m_y[i]), 10'(m_x[i]), 6'(m_dir[i])};
    return w;
  endfunction

  function automatic logic [33:0] slot(input int i);
    logic [33:0] w;
    w = entities[i*34 +: 34];
    return w;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < N; i++) if (!m_alive[i]) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_alive[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_ttl[i] = 0; m_alive[i] = 0;
    end
  endtask

  task automatic model_sweep();
    int h;
    for (int i = 0; i < N; i++) begin
      if (m_alive[i]) begin
        h = m_dir[i] / 4;
        m_x[i] = ((m_x[i] + dx_t[h] * SPEED) % W + W) % W;
        m_y[i] = ((m_y[i] + dy_t[h] * SPEED) % H + H) % H;
        if (m_ttl[i] != 0) begin
          m_ttl[i]--;
          if (m_ttl[i] == 0) m_alive[i] = 0;
        end
      end
    end
  endtask

  // ---------------- stimulus utilities ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick = 0; spawn_valid = 0; kill_valid = 0;
    reset_n = 0;
    repeat (2) step();
    reset_n = 1;
    step();
    model_clear();
  endtask

  task automatic do_spawn(input int x, input int y, input int dir, input int ttl);
    int s;
    int waited = 0;
    spawn_data  = {1'($urandom), 7'(ttl), 10'(y), 10'(x), 6'(dir)};
    spawn_valid = 1;
    while (!spawn_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!spawn_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL spawn_wait: spawn_ready=%0b required 1", spawn_ready);
      spawn_valid = 0;
      return;
    end
    step();
    spawn_valid = 0;
    s = model_free();
    if (s >= 0) begin
      m_x[s] = x; m_y[s] = y; m_dir[s] = dir; m_ttl[s] = ttl; m_alive[s] = 1;
    end
  endtask

  task automatic run_sweep();
    tick = 1;
    step();
    tick = 0;
    repeat (N + 1) step();
    model_sweep();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset_n = 0;
    step();
    vectors++;
    if (entities !== '0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        overrun_cnt !== 8'd0 || spawn_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%0b fd=%0b ovr=%0d ready=%0b ent_nonzero=%0b required all 0",
               busy, frame_done, overrun_cnt, spawn_ready, entities != '0);
    end
    reset_n = 1;
    step();
    vectors++;
    if (spawn_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: spawn_ready=%0b required 1", spawn_ready);
    end
    model_clear();
  endtask

  task automatic test_basic_move();
    do_reset();
    do_spawn(10, 20, 16, 0);
    vectors++;
    if (slot(0) !== exp_word(0) || alive_count !== 7'd1) begin
      miscompares++;
      $display("FAIL spawn_slot0: slot0=%h cnt=%0d required %h cnt 1", slot(0), alive_count, exp_word(0));
    end
    tick = 1;
    step();
    tick = 0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start: busy=%0b required 1", busy);
    end
    for (int k = 1; k <= N; k++) begin
      step();
      if (k == N - 1) begin
        vectors++;
        if (frame_done !== 1'b0) begin
          miscompares++;
          $display("FAIL frame_done_early: frame_done=%0b required 0", frame_done);
        end
      end
      if (k == N) begin
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL frame_done_pulse: fd=%0b busy=%0b required 1 1", frame_done, busy);
        end
      end
    end
    step();
    model_sweep();
    vectors++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_end: fd=%0b busy=%0b required 0 0", frame_done, busy);
    end
    vectors++;
    if (entities[15:6] !== 10'd12 || slot(0) !== exp_word(0)) begin
      miscompares++;
      $display("FAIL basic_move: slot0=%h required %h", slot(0), exp_word(0));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_spawn(319, 100, 16, 0);
    do_spawn(5, 0, 0, 0);
    run_sweep();
    vectors++;
    if (entities[15:6] !== 10'd1 || entities[34+16 +: 10] !== 10'd238) begin
      miscompares++;
      $display("FAIL wrap: x0=%0d y1=%0d required 1 238", entities[15:6], entities[34+16 +: 10]);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (slot(i) !== exp_word(i)) begin
        miscompares++;
        $display("FAIL wrap_table[%0d]: %h required %h", i, slot(i), exp_word(i));
      end
    end
  endtask

  task automatic test_ttl();
    do_reset();
    do_spawn(50, 60, int'($urandom_range(0, 63)), 2);
    vectors++;
    if (alive_count !== 7'd1) begin
      miscompares++;
      $display("FAIL ttl_count0: alive_count=%0d required 1", alive_count);
    end
    run_sweep();
    vectors++;
    if (slot(0) !== exp_word(0) || entities[33] !== 1'b1 || alive_count !== 7'd1) begin
      miscompares++;
      $display("FAIL ttl_first: slot0=%h cnt=%0d required %h cnt 1", slot(0), alive_count, exp_word(0));
    end
    run_sweep();
    vectors++;
    if (slot(0) !== exp_word(0) || entities[33] !== 1'b0 || alive_count !== 7'd0) begin
      miscompares++;
      $display("FAIL ttl_expire: slot0=%h cnt=%0d required %h cnt 0", slot(0), alive_count, exp_word(0));
    end
  endtask

  task automatic test_fill_kill();
    do_reset();
    for (int i = 0; i < N; i++)
      do_spawn(int'($urandom_range(0, W-1)), int'($urandom_range(0, H-1)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 5)));
    vectors++;
    if (spawn_ready !== 1'b0 || alive_count !== 7'(N)) begin
      miscompares++;
      $display("FAIL full: ready=%0b cnt=%0d required 0 %0d", spawn_ready, alive_count, N);
    end
    kill_valid = 1; kill_idx = 6'd12;
    step();
    kill_valid = 0;
    vectors++;
    if (alive_count !== 7'(N)) begin
      miscompares++;
      $display("FAIL kill_out_of_range: cnt=%0d required %0d", alive_count, N);
    end
    kill_valid = 1; kill_idx = 6'd3;
    step();
    kill_valid = 0;
    m_alive[3] = 0;
    vectors++;
    if (entities[3*34+33] !== 1'b0 || spawn_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL kill3: alive3=%0b ready=%0b required 0 1", entities[3*34+33], spawn_ready);
    end
    do_spawn(77, 88, 40, 0);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (slot(i) !== exp_word(i)) begin
        miscompares++;
        $display("FAIL refill_table[%0d]: %h required %h", i, slot(i), exp_word(i));
      end
    end
  endtask

  task automatic test_overrun_kill();
    do_reset();
    for (int i = 0; i < N; i++)
      do_spawn(int'($urandom_range(0, W-1)), int'($urandom_range(0, H-1)),
               int'($urandom_range(0, 63)), 0);
    tick = 1;
    step();                 // edge E
    tick = 0;
    repeat (3) step();      // after E+3
    tick = 1;
    step();                 // dropped at E+4
    tick = 0;
    step();                 // after E+5
    kill_valid = 1; kill_idx = 6'd5;
    step();                 // kill sampled at E+6 with slot 5
    kill_valid = 0;
    repeat (N - 5) step();  // after E+N+1
    model_sweep();
    m_alive[5] = 0;
    vectors++;
    if (overrun_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL overrun: overrun_cnt=%0d required 1", overrun_cnt);
    end
    vectors++;
    if (entities[5*34+6 +: 10] !== 10'(m_x[5]) || entities[5*34+33] !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_during_sweep: slot5=%h required %h", slot(5), exp_word(5));
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (slot(i) !== exp_word(i)) begin
        miscompares++;
        $display("FAIL overrun_table[%0d]: %h required %h", i, slot(i), exp_word(i));
      end
    end
  endtask

  task automatic test_random();
    int n_sp;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      n_sp = int'($urandom_range(0, 2));
      for (int s = 0; s < n_sp; s++) begin
        vectors++;
        if (spawn_ready !== (model_free() >= 0)) begin
          miscompares++;
          $display("FAIL rand_ready it%0d: ready=%0b required %0b", it, spawn_ready, model_free() >= 0);
        end
        if (model_free() >= 0)
          do_spawn(int'($urandom_range(0, W-1)), int'($urandom_range(0, H-1)),
                   int'($urandom_range(0, 63)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
      end
      if ($urandom_range(0, 1) == 1) begin
        kill_idx   = 6'($urandom_range(0, 15));
        kill_valid = 1;
        step();
        kill_valid = 0;
        if (int'(kill_idx) < N) m_alive[kill_idx] = 0;
      end
      run_sweep();
      vectors++;
      if (alive_count !== 7'(model_count())) begin
        miscompares++;
        $display("FAIL rand_count it%0d: cnt=%0d required %0d", it, alive_count, model_count());
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (slot(i) !== exp_word(i)) begin
          miscompares++;
          $display("FAIL rand_table it%0d[%0d]: %h required %h", it, i, slot(i), exp_word(i));
        end
      end
    end
  endtask

  task automatic test_reset_midsweep();
    bit quiet = 1;
    do_reset();
    for (int i = 0; i < 3; i++) do_spawn(100 + i, 50, 8 * i, 0);
    tick = 1;
    step();               // edge E
    tick = 0;
    repeat (5) step();    // after E+5
    reset_n = 0;
    #1;
    vectors++;
    if (entities !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || spawn_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midsweep_reset: busy=%0b fd=%0b ready=%0b ent_nonzero=%0b required all 0",
               busy, frame_done, spawn_ready, entities != '0);
    end
    repeat (3) begin
      step();
      if (frame_done !== 1'b0) quiet = 0;
    end
    reset_n = 1;
    vectors++;
    if (spawn_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_ready_early: spawn_ready=%0b required 0", spawn_ready);
    end
    step();
    vectors++;
    if (spawn_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: spawn_ready=%0b required 1", spawn_ready);
    end
    repeat (N + 2) begin
      step();
      if (frame_done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("FAIL aborted_sweep_quiet: saw frame_done/busy=%0b required 0", !quiet);
    end
    model_clear();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_move();
    test_wrap();
    test_ttl();
    test_fill_kill();
    test_overrun_kill();
    test_random();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
